// File: rtl/mem_arb_defs.sv
// Shared definitions for the two-master memory arbiter: FSM encoding and the
// read data returned when a read times out.
package mem_arb_defs;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2,
    RSP     = 2'd3
  } state_t;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arb_rr_arb2.sv
// Two-way round-robin selector; combinational one-hot grant, pointer updated on strobe.
// After reset the pointer marks master 1 as last granted, so master 0 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant,
  output logic       last_grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_grant <= 1'b1;
    else if (update && (|grant))
      last_grant <= grant[1];
  end

endmodule

// File: rtl/mem_arb.sv
// Two-master to one-slave memory arbiter: one command in flight, reads wait for the slave.
// Optional read timeout (returns 32'hDEADBEEF, sets sticky timeout_err) under MEM_ARB_TIMEOUT_EN.
module mem_arb
  import mem_arb_defs::*;
#(
  parameter int ADDR_W         = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_cmd_valid,
  output logic              m0_cmd_ready,
  input  logic              m0_cmd_wr,
  input  logic [ADDR_W-1:0] m0_cmd_addr,
  input  logic [31:0]       m0_cmd_wdata,
  output logic              m0_rsp_ready,
  output logic [31:0]       m0_rsp_rdata,
  input  logic              m1_cmd_valid,
  output logic              m1_cmd_ready,
  input  logic              m1_cmd_wr,
  input  logic [ADDR_W-1:0] m1_cmd_addr,
  input  logic [31:0]       m1_cmd_wdata,
  output logic              m1_rsp_ready,
  output logic [31:0]       m1_rsp_rdata,
  output logic              mem_cmd_valid,
  output logic              mem_cmd_wr,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic [31:0]       mem_cmd_wdata,
  input  logic              mem_rsp_ready,
  input  logic [31:0]       mem_rsp_rdata,
  output logic              timeout_err
);

  state_t              r_state;
  state_t              w_next;
  logic                r_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_m0_rdata;
  logic [31:0]         r_m1_rdata;
  logic [1:0]          w_req;
  logic [1:0]          w_grant;
  logic                w_owner;
  logic                w_latch;
  logic                w_capture;
  logic [31:0]         w_cap_data;
  logic                w_issue;
  logic                w_rsp;

  assign w_req = {m1_cmd_valid, m0_cmd_valid};

  // The pointer is updated with the winner when the command is latched, so it
  // doubles as the owner id for the rest of the transaction.
  rr_arb2 u_rr (
    .clk        (clk),
    .reset      (reset),
    .req        (w_req),
    .update     (w_latch),
    .grant      (w_grant),
    .last_grant (w_owner)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  logic [31:0] r_to_cnt;
  logic        r_to_err;
  logic        w_to_hit;

  assign w_to_hit    = (r_to_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign timeout_err = r_to_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt <= '0;
      r_to_err <= 1'b0;
    end else begin
      r_to_cnt <= (r_state == RD_WAIT) ? r_to_cnt + 32'd1 : '0;
      if ((r_state == RD_WAIT) && !mem_rsp_ready && w_to_hit)
        r_to_err <= 1'b1;
    end
  end
`else
  assign timeout_err = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    w_next     = r_state;
    w_latch    = 1'b0;
    w_capture  = 1'b0;
    w_cap_data = mem_rsp_rdata;
    case (r_state)
      IDLE: begin
        if (|w_grant) begin
          w_latch = 1'b1;
          w_next  = ISSUE;
        end
      end
      ISSUE:   w_next = r_wr ? IDLE : RD_WAIT;
      RD_WAIT: begin
        if (mem_rsp_ready) begin
          w_capture = 1'b1;
          w_next    = RSP;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (w_to_hit) begin
          w_capture  = 1'b1;
          w_cap_data = TIMEOUT_DATA;
          w_next     = RSP;
        end
`endif
      end
      RSP:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_latch) begin
      r_wr    <= w_grant[1] ? m1_cmd_wr    : m0_cmd_wr;
      r_addr  <= w_grant[1] ? m1_cmd_addr  : m0_cmd_addr;
      r_wdata <= w_grant[1] ? m1_cmd_wdata : m0_cmd_wdata;
    end
  end

  // Each master's rdata register only changes on its own response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
    end else if (w_capture) begin
      if (w_owner) r_m1_rdata <= w_cap_data;
      else         r_m0_rdata <= w_cap_data;
    end
  end

  assign w_issue       = (r_state == ISSUE);
  assign w_rsp         = (r_state == RSP);
  assign mem_cmd_valid = w_issue;
  assign mem_cmd_wr    = w_issue & r_wr;
  assign mem_cmd_addr  = w_issue ? r_addr  : '0;
  assign mem_cmd_wdata = w_issue ? r_wdata : '0;
  assign m0_cmd_ready  = w_issue & ~w_owner;
  assign m1_cmd_ready  = w_issue &  w_owner;
  assign m0_rsp_ready  = w_rsp   & ~w_owner;
  assign m1_rsp_ready  = w_rsp   &  w_owner;
  assign m0_rsp_rdata  = r_m0_rdata;
  assign m1_rsp_rdata  = r_m1_rdata;

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: planned transaction order feeds expected queues, a monitor checks.
module tb_mem_arb;
  localparam int AW = 12;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          m0_cmd_valid = 1'b0, m0_cmd_wr = 1'b0;
  logic [AW-1:0] m0_cmd_addr = '0;
  logic [31:0]   m0_cmd_wdata = '0;
  logic          m0_cmd_ready, m0_rsp_ready;
  logic [31:0]   m0_rsp_rdata;
  logic          m1_cmd_valid = 1'b0, m1_cmd_wr = 1'b0;
  logic [AW-1:0] m1_cmd_addr = '0;
  logic [31:0]   m1_cmd_wdata = '0;
  logic          m1_cmd_ready, m1_rsp_ready;
  logic [31:0]   m1_rsp_rdata;
  logic          mem_cmd_valid, mem_cmd_wr;
  logic [AW-1:0] mem_cmd_addr;
  logic [31:0]   mem_cmd_wdata;
  logic          mem_rsp_ready = 1'b0;
  logic [31:0]   mem_rsp_rdata = '0;
  logic          timeout_err;

  mem_arb #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready), .m0_cmd_wr(m0_cmd_wr),
    .m0_cmd_addr(m0_cmd_addr), .m0_cmd_wdata(m0_cmd_wdata),
    .m0_rsp_ready(m0_rsp_ready), .m0_rsp_rdata(m0_rsp_rdata),
    .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(m1_cmd_ready), .m1_cmd_wr(m1_cmd_wr),
    .m1_cmd_addr(m1_cmd_addr), .m1_cmd_wdata(m1_cmd_wdata),
    .m1_rsp_ready(m1_rsp_ready), .m1_rsp_rdata(m1_rsp_rdata),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_wr(mem_cmd_wr),
    .mem_cmd_addr(mem_cmd_addr), .mem_cmd_wdata(mem_cmd_wdata),
    .mem_rsp_ready(mem_rsp_ready), .mem_rsp_rdata(mem_rsp_rdata),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct { bit wr; logic [AW-1:0] addr; logic [31:0] wdata; } tx_t;
  typedef struct { bit m; bit wr; logic [AW-1:0] addr; logic [31:0] data; int cyc; } cmd_t;
  typedef struct { bit m; logic [31:0] data; int cyc; bit to; } rsp_t;

  tx_t  st0[$], st1[$], txq0[$], txq1[$];
  cmd_t exp_cmd[$];
  rsp_t exp_rsp[$];
  logic [31:0] model_mem [64];
  logic [31:0] slave_mem [64];
  logic [31:0] exp_rd [2];
  bit   exp_te;
  bit   model_last;
  bit   flush, slave_mute, spur_en;
  int   slave_delay;
  int   cyc = 0;
  int   checks = 0, errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: serve pending requests one at a time, alternating when both wait.
  task automatic plan();
    int  t;
    bit  known;
    bit  pick;
    tx_t x;
    cmd_t c;
    rsp_t r;
    t = cyc + 1;
    known = 1'b1;
    while (st0.size() > 0 || st1.size() > 0) begin
      if (st0.size() > 0 && st1.size() > 0) pick = ~model_last;
      else pick = (st0.size() == 0);
      x = pick ? st1.pop_front() : st0.pop_front();
      if (pick) txq1.push_back(x); else txq0.push_back(x);
      model_last = pick;
      c = '{m: pick, wr: x.wr, addr: x.addr, data: x.wdata, cyc: known ? t + 1 : -1};
      exp_cmd.push_back(c);
      if (x.wr) begin
        model_mem[x.addr[7:2]] = x.wdata;
        t += 2;
      end else if (slave_mute) begin
`ifdef MEM_ARB_TIMEOUT_EN
        r = '{m: pick, data: 32'hDEADBEEF, cyc: known ? t + 2 + TO : -1, to: 1'b1};
        exp_rsp.push_back(r);
`endif
        known = 1'b0;
      end else begin
        r = '{m: pick, data: model_mem[x.addr[7:2]], cyc: -1, to: 1'b0};
        if (known && slave_delay > 0) r.cyc = t + 2 + slave_delay;
        else known = 1'b0;
        exp_rsp.push_back(r);
        t += slave_delay + 3;
      end
    end
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_ctl"}, 32'({m0_cmd_ready, m0_rsp_ready, m1_cmd_ready, m1_rsp_ready,
                          mem_cmd_valid, mem_cmd_wr, timeout_err}), 32'd0);
    chk({nm, "_addr"}, 32'(mem_cmd_addr), 32'd0);
    chk({nm, "_wdata"}, mem_cmd_wdata, 32'd0);
    chk({nm, "_rdata0"}, m0_rsp_rdata, 32'd0);
    chk({nm, "_rdata1"}, m1_rsp_rdata, 32'd0);
  endtask

  task automatic do_reset(input int hold);
    flush = 1'b1;
    reset = 1'b1;
    exp_cmd.delete();
    exp_rsp.delete();
    model_last = 1'b1;
    #1;
    check_all_zero("reset_out");
    repeat (hold) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #2;
    flush = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_cmd.size() + exp_rsp.size() + txq0.size() + txq1.size()) > 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= budget) begin
      chk("drain_pending", 32'(exp_cmd.size() + exp_rsp.size() + txq0.size() + txq1.size()), 32'd0);
      do_reset(2);
    end
  endtask

  initial begin : drv0
    bit done0;
    forever begin
      @(negedge clk);
      done0 = m0_cmd_valid && m0_cmd_ready;
      @(posedge clk);
      #1;
      if (flush) txq0.delete();
      else if (done0 && txq0.size() > 0) void'(txq0.pop_front());
      if (txq0.size() > 0) begin
        m0_cmd_valid = 1'b1; m0_cmd_wr = txq0[0].wr;
        m0_cmd_addr = txq0[0].addr; m0_cmd_wdata = txq0[0].wdata;
      end else begin
        m0_cmd_valid = 1'b0; m0_cmd_wr = 1'b0; m0_cmd_addr = '0; m0_cmd_wdata = '0;
      end
    end
  end

  initial begin : drv1
    bit done1;
    forever begin
      @(negedge clk);
      done1 = m1_cmd_valid && m1_cmd_ready;
      @(posedge clk);
      #1;
      if (flush) txq1.delete();
      else if (done1 && txq1.size() > 0) void'(txq1.pop_front());
      if (txq1.size() > 0) begin
        m1_cmd_valid = 1'b1; m1_cmd_wr = txq1[0].wr;
        m1_cmd_addr = txq1[0].addr; m1_cmd_wdata = txq1[0].wdata;
      end else begin
        m1_cmd_valid = 1'b0; m1_cmd_wr = 1'b0; m1_cmd_addr = '0; m1_cmd_wdata = '0;
      end
    end
  end

  // Slave: answers reads after a delay, and pulses stray responses when idle.
  initial begin : slave
    int cnt;
    logic [5:0] pidx;
    cnt = 0;
    pidx = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_rsp_ready = 1'b0;
      if (mem_cmd_valid && mem_cmd_wr) slave_mem[mem_cmd_addr[7:2]] = mem_cmd_wdata;
      if (mem_cmd_valid && !mem_cmd_wr) begin
        if (!slave_mute) begin
          cnt = (slave_delay > 0) ? slave_delay : int'($urandom_range(1, 3));
          pidx = mem_cmd_addr[7:2];
        end
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mem_rsp_ready = 1'b1;
          mem_rsp_rdata = slave_mem[pidx];
        end
      end else if (spur_en && !slave_mute && $urandom_range(0, 3) == 0) begin
        mem_rsp_ready = 1'b1;
        mem_rsp_rdata = $urandom;
      end
    end
  end

  initial begin : monitor
    cmd_t c;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        exp_te = 1'b0;
      end else begin
        if (mem_cmd_valid) begin
          chk("cmd_expected", 32'(exp_cmd.size() > 0), 32'd1);
          if (exp_cmd.size() > 0) begin
            c = exp_cmd.pop_front();
            chk("cmd_owner", 32'({m1_cmd_ready, m0_cmd_ready}), c.m ? 32'd2 : 32'd1);
            chk("cmd_wr", 32'(mem_cmd_wr), 32'(c.wr));
            chk("cmd_addr", 32'(mem_cmd_addr), 32'(c.addr));
            chk("cmd_wdata", mem_cmd_wdata, c.data);
            if (c.cyc >= 0) chk("cmd_cycle", 32'(cyc), 32'(c.cyc));
          end
        end else begin
          chk("idle_bus", 32'({m1_cmd_ready, m0_cmd_ready, mem_cmd_wr,
                               |mem_cmd_addr, |mem_cmd_wdata}), 32'd0);
        end
        if (m0_rsp_ready || m1_rsp_ready) begin
          chk("rsp_expected", 32'(exp_rsp.size() > 0), 32'd1);
          if (exp_rsp.size() > 0) begin
            r = exp_rsp.pop_front();
            chk("rsp_owner", 32'({m1_rsp_ready, m0_rsp_ready}), r.m ? 32'd2 : 32'd1);
            exp_rd[r.m] = r.data;
            if (r.to) exp_te = 1'b1;
            if (r.cyc >= 0) chk("rsp_cycle", 32'(cyc), 32'(r.cyc));
          end
        end
        chk("rdata0", m0_rsp_rdata, exp_rd[0]);
        chk("rdata1", m1_rsp_rdata, exp_rd[1]);
        chk("timeout_err", 32'(timeout_err), 32'(exp_te));
      end
    end
  end

  initial begin : main
    int v;
    int n0, n1;
    logic [AW-1:0] a;
    slave_delay = 1;
    slave_mute = 1'b0;
    spur_en = 1'b0;
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      model_mem[i] = v;
      slave_mem[i] = v;
    end
    model_mem[3] = 32'h0000_003C;
    slave_mem[3] = 32'h0000_003C;
    do_reset(3);

    // Two back-to-back m0 writes, first is addr 004 / A5.
    @(negedge clk);
    st0.push_back('{wr: 1'b1, addr: 12'h004, wdata: 32'h0000_00A5});
    st0.push_back('{wr: 1'b1, addr: 12'h008, wdata: $urandom});
    plan();
    drain(100);

    // m1 read of 00C, slave answers one cycle after the command.
    @(negedge clk);
    st1.push_back('{wr: 1'b0, addr: 12'h00C, wdata: 32'h0});
    plan();
    drain(100);

    // Contention: both masters hold valid for four transactions.
    spur_en = 1'b1;
    @(negedge clk);
    st0.push_back('{wr: 1'b1, addr: 12'h010, wdata: $urandom});
    st1.push_back('{wr: 1'b0, addr: 12'h010, wdata: $urandom});
    st0.push_back('{wr: 1'b0, addr: 12'h004, wdata: $urandom});
    st1.push_back('{wr: 1'b1, addr: 12'h014, wdata: $urandom});
    plan();
    drain(200);

    // Random traffic with random slave delays.
    slave_delay = 0;
    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      n0 = $urandom_range(0, 5);
      n1 = $urandom_range(0, 5);
      for (int k = 0; k < n0; k++) begin
        a = AW'($urandom_range(0, 63)) << 2;
        st0.push_back('{wr: 1'($urandom_range(0, 1)), addr: a, wdata: $urandom});
      end
      for (int k = 0; k < n1; k++) begin
        a = AW'($urandom_range(0, 63)) << 2;
        st1.push_back('{wr: 1'($urandom_range(0, 1)), addr: a, wdata: $urandom});
      end
      plan();
      drain(600);
    end

    // m0 read with a slave that never answers.
    spur_en = 1'b0;
    slave_mute = 1'b1;
    @(negedge clk);
    st0.push_back('{wr: 1'b0, addr: 12'h020, wdata: 32'h0});
    plan();
`ifdef MEM_ARB_TIMEOUT_EN
    drain(100);
    repeat (5) @(negedge clk);
    #1;
    chk("timeout_sticky", 32'(timeout_err), 32'd1);
`else
    repeat (100) @(negedge clk);
    #1;
    chk("no_timeout_err", 32'(timeout_err), 32'd0);
    chk("read_still_pending", 32'(exp_cmd.size()), 32'd0);
`endif
    slave_mute = 1'b0;
    do_reset(2);

    // Load both rdata registers, then reset during a slow read.
    slave_delay = 1;
    @(negedge clk);
    st0.push_back('{wr: 1'b0, addr: 12'h00C, wdata: 32'h0});
    st1.push_back('{wr: 1'b0, addr: 12'h00C, wdata: 32'h0});
    plan();
    drain(100);
    slave_delay = 6;
    @(negedge clk);
    txq0.push_back('{wr: 1'b0, addr: 12'h00C, wdata: 32'h0});
    exp_cmd.push_back('{m: 1'b0, wr: 1'b0, addr: 12'h00C, data: 32'h0, cyc: cyc + 2});
    repeat (4) @(posedge clk);
    #2;
    do_reset(2);
    slave_delay = 1;
    repeat (8) @(negedge clk);

    // Tie right after reset goes to m0.
    @(negedge clk);
    st0.push_back('{wr: 1'b1, addr: 12'h030, wdata: $urandom});
    st1.push_back('{wr: 1'b1, addr: 12'h034, wdata: $urandom});
    plan();
    drain(100);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
